// File: rtl/ifm_chunk_loader_if.sv
// Input beat stream into the IFM chunk loader: dense bytes, valid/ready
// handshake and an end-of-frame marker.
interface ifm_chunk_loader_if #(
  parameter int BUS_SIZE = 32
);
  logic [BUS_SIZE-1:0][7:0] in_data;
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;

  modport master (output in_data, in_valid, in_last, input  in_ready);
  modport slave  (input  in_data, in_valid, in_last, output in_ready);
endinterface

// File: rtl/ifm_chunk_loader.sv
// IFM chunk loader: turns dense byte beats into sparsemap + left-compacted
// nonzero bytes and writes them into a ping-pong chunk store, padding short
// final chunks and tracking per-buffer full / read-select status.
// Optional per-buffer nonzero byte counters: define IFM_LOADER_NZCNT_EN.
module ifm_chunk_loader #(
  parameter int BUS_SIZE       = 32,
  parameter int WR_DAT_CYC_NUM = 4,
  parameter int CW             = $clog2(WR_DAT_CYC_NUM),
  localparam int NZW           = $clog2(BUS_SIZE*WR_DAT_CYC_NUM) + 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  ifm_chunk_loader_if.slave        in_if,
  output logic [BUS_SIZE-1:0]      wr_sparsemap_o,
  output logic [BUS_SIZE-1:0][7:0] wr_nonzero_data_o,
  output logic                     wr_valid_o,
  output logic [CW-1:0]            wr_count_o,
  output logic                     wr_sel_o,
  output logic [1:0]               full_o,
  output logic                     rd_sel_o,
`ifdef IFM_LOADER_NZCNT_EN
  output logic [1:0][NZW-1:0]      nz_count_o,
`endif
  input  logic                     rd_done_i
);

  localparam int SIW = $clog2(BUS_SIZE);
  localparam int PW  = SIW + 1;

  typedef enum logic {S_FILL, S_PAD} state_t;

  state_t                   r_state, w_state_nxt;
  logic [CW-1:0]            r_cnt;
  logic                     r_wr_sel, r_rd_sel;
  logic [1:0]               r_full;
  logic [BUS_SIZE-1:0]      r_smap;
  logic [BUS_SIZE-1:0][7:0] r_nz;
  logic                     r_wr_valid;
  logic [CW-1:0]            r_wr_count;
  logic                     r_wr_sel_o;

  logic                     w_in_ready, w_acc, w_wr_beat, w_cnt_last;
  logic [BUS_SIZE-1:0]      w_smap;
  logic [BUS_SIZE-1:0][7:0] w_nz;
  logic                     w_chunk_done;
  logic [1:0]               w_set, w_clr;

  // Ready comes only from registers; held low while reset is asserted.
  assign w_in_ready     = rst_i && (r_state == S_FILL) && !r_full[r_wr_sel];
  assign in_if.in_ready = w_in_ready;
  assign w_acc          = in_if.in_valid && w_in_ready;
  assign w_wr_beat      = w_acc || (r_state == S_PAD);
  assign w_cnt_last     = (r_cnt == CW'(WR_DAT_CYC_NUM-1));

  for (genvar k = 0; k < BUS_SIZE; k++) begin : g_smap
    assign w_smap[k] = |in_if.in_data[k];
  end

  // Left-compact nonzero bytes in ascending byte order; unused slots stay 0.
  always_comb begin
    logic [SIW:0] slot;
    w_nz = '0;
    slot = '0;
    for (int k = 0; k < BUS_SIZE; k++) begin
      if (w_smap[k]) begin
        w_nz[slot[SIW-1:0]] = in_if.in_data[k];
        slot = slot + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_FILL;
    else        r_state <= w_state_nxt;
  end

  // Short final chunk drops into PAD until the chunk's last slot is written.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_acc && in_if.in_last && !w_cnt_last) w_state_nxt = S_PAD;
      S_PAD:   if (w_cnt_last)                            w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Write-port registers: real beats on accept, zero beats while padding.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_smap     <= '0;
      r_nz       <= '0;
      r_wr_valid <= 1'b0;
      r_wr_count <= '0;
      r_wr_sel_o <= 1'b0;
    end else if (w_acc) begin
      r_smap     <= w_smap;
      r_nz       <= w_nz;
      r_wr_valid <= 1'b1;
      r_wr_count <= r_cnt;
      r_wr_sel_o <= r_wr_sel;
    end else if (r_state == S_PAD) begin
      r_smap     <= '0;
      r_nz       <= '0;
      r_wr_valid <= 1'b1;
      r_wr_count <= r_cnt;
      r_wr_sel_o <= r_wr_sel;
    end else begin
      r_wr_valid <= 1'b0;
    end
  end

  // Beat counter within the chunk; buffer select flips after the last beat.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt    <= '0;
      r_wr_sel <= 1'b0;
    end else if (w_wr_beat) begin
      if (w_cnt_last) begin
        r_cnt    <= '0;
        r_wr_sel <= ~r_wr_sel;
      end else begin
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  // A buffer is full one edge after its last beat reaches the store; the
  // consumer releases buffers in order, set/clear of different buffers merge.
  assign w_chunk_done = r_wr_valid && (r_wr_count == CW'(WR_DAT_CYC_NUM-1));
  assign w_set = {w_chunk_done &&  r_wr_sel_o, w_chunk_done && !r_wr_sel_o};
  assign w_clr = {rd_done_i && r_full[r_rd_sel] &&  r_rd_sel,
                  rd_done_i && r_full[r_rd_sel] && !r_rd_sel};

  // Full flags and read select.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_full   <= 2'b00;
      r_rd_sel <= 1'b0;
    end else begin
      r_full <= (r_full & ~w_clr) | w_set;
      if (|w_clr) r_rd_sel <= ~r_rd_sel;
    end
  end

  assign wr_sparsemap_o    = r_smap;
  assign wr_nonzero_data_o = r_nz;
  assign wr_valid_o        = r_wr_valid;
  assign wr_count_o        = r_wr_count;
  assign wr_sel_o          = r_wr_sel_o;
  assign full_o            = r_full;
  assign rd_sel_o          = r_rd_sel;

`ifdef IFM_LOADER_NZCNT_EN
  logic [PW-1:0]          w_pop;
  logic [1:0][NZW-1:0]    r_nzcnt;

  // Nonzero bytes in the incoming beat.
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < BUS_SIZE; k++) w_pop = w_pop + PW'(w_smap[k]);
  end

  // Per-buffer nonzero tally; restarts with the first beat of a chunk.
  // Pad beats carry no nonzero bytes, so only real accepts update it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_nzcnt <= '0;
    end else if (w_acc) begin
      if (r_cnt == '0) r_nzcnt[r_wr_sel] <= NZW'(w_pop);
      else             r_nzcnt[r_wr_sel] <= r_nzcnt[r_wr_sel] + NZW'(w_pop);
    end
  end

  assign nz_count_o = r_nzcnt;
`endif

endmodule

// File: tb/tb_ifm_chunk_loader.sv
// Scoreboard bench for ifm_chunk_loader: a stimulus process pushes expected
// writes computed from the beat contents; a negedge monitor pops and compares
// them and tracks the buffer full/read-select status at chunk level.
module tb_ifm_chunk_loader;
  localparam int BS  = 32;
  localparam int N   = 4;
  localparam int CW  = $clog2(N);
  localparam int NZW = $clog2(BS*N) + 1;

  typedef logic [BS-1:0][7:0] beat_t;
  typedef struct {
    logic [BS-1:0] smap;
    beat_t         dat;
    int            cnt;
    int            sel;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd_done = 1'b0;
  logic [BS-1:0] wr_sparsemap;
  beat_t         wr_data;
  logic          wr_valid;
  logic [CW-1:0] wr_count;
  logic          wr_sel;
  logic [1:0]    full;
  logic          rd_sel;
`ifdef IFM_LOADER_NZCNT_EN
  logic [1:0][NZW-1:0] nz_count;
`endif

  ifm_chunk_loader_if #(.BUS_SIZE(BS)) bus ();

  ifm_chunk_loader #(.BUS_SIZE(BS), .WR_DAT_CYC_NUM(N)) dut (
    .clk_i(clk), .rst_i(rst_n), .in_if(bus),
    .wr_sparsemap_o(wr_sparsemap), .wr_nonzero_data_o(wr_data),
    .wr_valid_o(wr_valid), .wr_count_o(wr_count), .wr_sel_o(wr_sel),
    .full_o(full), .rd_sel_o(rd_sel),
`ifdef IFM_LOADER_NZCNT_EN
    .nz_count_o(nz_count),
`endif
    .rd_done_i(rd_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  wr_t q[$];
  bit  mon_en  = 1'b0;
  bit  rand_rd = 1'b0;

  // model state: stimulus side (chunk position) and consumer side (buffers)
  int m_cnt = 0, m_sel = 0;
  bit [1:0] m_full = 2'b00;
  int m_rd = 0;
  int m_nz [2] = '{0, 0};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected store write for a dense beat, straight from the byte values.
  function automatic wr_t mk_wr(input beat_t d);
    wr_t r;
    int  j = 0;
    r.smap = '0; r.dat = '0; r.cnt = 0; r.sel = 0;
    for (int k = 0; k < BS; k++)
      if (d[k] != 8'h00) begin
        r.smap[k] = 1'b1;
        r.dat[j]  = d[k];
        j++;
      end
    return r;
  endfunction

  function automatic int popc(input beat_t d);
    int n = 0;
    for (int k = 0; k < BS; k++) if (d[k] != 8'h00) n++;
    return n;
  endfunction

  task automatic model_accept(input beat_t d, input bit last);
    wr_t e;
    e = mk_wr(d);
    e.cnt = m_cnt; e.sel = m_sel;
    q.push_back(e);
    m_nz[m_sel] = (m_cnt == 0) ? popc(d) : m_nz[m_sel] + popc(d);
    if (last) begin
      // remainder of the chunk is filled with empty beats
      while (m_cnt != N-1) begin
        m_cnt++;
        e.smap = '0; e.dat = '0; e.cnt = m_cnt; e.sel = m_sel;
        q.push_back(e);
      end
    end
    if (m_cnt == N-1) begin m_cnt = 0; m_sel ^= 1; end
    else m_cnt++;
  endtask

  // Call just after a posedge; returns just after the accepting posedge.
  task automatic send_beat(input beat_t d, input bit last);
    int guard = 0;
    bus.in_data = d; bus.in_last = last; bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin model_accept(d, last); break; end
      guard++;
      if (guard > 2000) begin
        chk("accept_timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic pulse_rd();
    @(posedge clk); #1 rd_done = 1'b1;
    @(posedge clk); #1 rd_done = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic beat_t rnd_beat();
    beat_t d;
    int dens = $urandom_range(0, 4);
    for (int k = 0; k < BS; k++)
      d[k] = ($urandom_range(0, 3) < dens) ? 8'h00 : 8'($urandom_range(1, 255));
    return d;
  endfunction

  // Monitor: status compare first (reflects the last edge), then fold in
  // what the coming edge will do.
  always @(negedge clk) begin
    wr_t e;
    if (mon_en) begin
      chk("full", 256'(full), 256'(m_full));
      chk("rd_sel", 256'(rd_sel), 256'(m_rd));
`ifdef IFM_LOADER_NZCNT_EN
      for (int b = 0; b < 2; b++)
        if (m_full[b]) chk("nz_count", 256'(nz_count[b]), 256'(m_nz[b]));
`endif
      if (rd_done && m_full[m_rd]) begin m_full[m_rd] = 1'b0; m_rd ^= 1; end
      if (wr_valid) begin
        if (q.size() == 0) chk("unexpected_write", 256'(1), 256'(0));
        else begin
          e = q.pop_front();
          chk("wr_sparsemap", 256'(wr_sparsemap), 256'(e.smap));
          chk("wr_nonzero_data", wr_data, e.dat);
          chk("wr_count", 256'(wr_count), 256'(e.cnt));
          chk("wr_sel", 256'(wr_sel), 256'(e.sel));
          if (e.cnt == N-1) m_full[e.sel] = 1'b1;
        end
      end
    end
  end

  // Random consumer releases during the soak phase.
  initial forever begin
    @(posedge clk); #1;
    if (rand_rd) rd_done = ($urandom_range(0, 3) == 0);
  end

  initial begin
    beat_t d;
    int guard;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;

    // reset state
    #12;
    chk("rst_in_ready", 256'(bus.in_ready), 256'(0));
    chk("rst_wr_valid", 256'(wr_valid), 256'(0));
    chk("rst_full", 256'(full), 256'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 256'(bus.in_ready), 256'(1));
    @(posedge clk); #1;

    // two chunks, no release: 0x11/0x22 beat, all-nonzero beats, random beats
    d = '0; d[0] = 8'h11; d[3] = 8'h22;
    send_beat(d, 1'b0);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < BS; k++) d[k] = 8'($urandom_range(1, 255));
      send_beat(d, 1'b0);
    end
    for (int i = 0; i < 4; i++) send_beat(rnd_beat(), 1'b0);
    wait_cyc(3);
    @(negedge clk);
    chk("both_full", 256'(full), 256'(2'b11));
    chk("backpressure_ready", 256'(bus.in_ready), 256'(0));
    chk("rd_sel_oldest", 256'(rd_sel), 256'(0));
    pulse_rd();
    @(negedge clk);
    chk("release_full", 256'(full), 256'(2'b10));
    chk("release_rd_sel", 256'(rd_sel), 256'(1));
    chk("release_ready", 256'(bus.in_ready), 256'(1));
    pulse_rd();
    wait_cyc(1);

    // short final chunk: last on count 1 -> pads at 2,3
    send_beat(rnd_beat(), 1'b0);
    send_beat(rnd_beat(), 1'b1);
    @(negedge clk); chk("pad_ready0", 256'(bus.in_ready), 256'(0));
    @(negedge clk); chk("pad_ready1", 256'(bus.in_ready), 256'(0));
    @(negedge clk); chk("pad_done_ready", 256'(bus.in_ready), 256'(1));
    pulse_rd();
    wait_cyc(1);

    // reset mid-chunk (count 2 into buffer 1)
    for (int i = 0; i < 3; i++) send_beat(rnd_beat(), 1'b0);
    wait_cyc(1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_valid", 256'(wr_valid), 256'(0));
    chk("midrst_wr_count", 256'(wr_count), 256'(0));
    chk("midrst_full", 256'(full), 256'(0));
    chk("midrst_sparsemap", 256'(wr_sparsemap), 256'(0));
    chk("midrst_in_ready", 256'(bus.in_ready), 256'(0));
    q.delete();
    m_cnt = 0; m_sel = 0; m_full = 2'b00; m_rd = 0; m_nz = '{0, 0};
    wait_cyc(2);
    rst_n = 1'b1;
    mon_en = 1'b1;
    wait_cyc(1);

    // chunk with 5,0,32,1 nonzero bytes into buffer 0
    d = '0; for (int k = 0; k < 5; k++) d[k*6] = 8'(k + 1);
    send_beat(d, 1'b0);
    d = '0;
    send_beat(d, 1'b0);
    for (int k = 0; k < BS; k++) d[k] = 8'(k + 100);
    send_beat(d, 1'b0);
    d = '0; d[BS-1] = 8'hFF;
    send_beat(d, 1'b0);
    wait_cyc(2);
    @(negedge clk);
    chk("nz_chunk_full", 256'(full), 256'(2'b01));
`ifdef IFM_LOADER_NZCNT_EN
    chk("nz_count_38", 256'(nz_count[0]), 256'(38));
`endif
    pulse_rd();
    wait_cyc(1);

    // random soak with random releases and frame ends
    rand_rd = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_beat(rnd_beat(), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 3) == 0) wait_cyc($urandom_range(1, 3));
    end
    guard = 0;
    while (q.size() != 0 && guard < 200) begin wait_cyc(1); guard++; end
    rand_rd = 1'b0;
    rd_done = 1'b0;
    wait_cyc(3);
    chk("scoreboard_drained", 256'(q.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
